// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired control unit: opcodes, ALU select,
// FSM step states, instruction classes and the registered strobe bundle.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
                           OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101,
                           OP_OR   = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000,
                           OP_SHR  = 5'b01001, OP_SHRA = 5'b01010, OP_ADDI = 5'b01011,
                           OP_ANDI = 5'b01100, OP_ORI  = 5'b01101, OP_MUL  = 5'b01110,
                           OP_DIV  = 5'b01111, OP_NEG  = 5'b10000, OP_NOT  = 5'b10001,
                           OP_BR   = 5'b10010, OP_JR   = 5'b10011, OP_IN   = 5'b10100,
                           OP_OUT  = 5'b10101, OP_MFLO = 5'b10110, OP_MFHI = 5'b10111,
                           OP_NOP  = 5'b11000, OP_HALT = 5'b11001, OP_SHL  = 5'b11010;

    typedef enum logic [3:0] {
        ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SHL, ALU_SHR, ALU_SHRA,
        ALU_ROR, ALU_ROL, ALU_MUL, ALU_DIV, ALU_NEG, ALU_NOT
    } alu_op_e;

    typedef enum logic [3:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        CL_NOP, CL_HALT, CL_ALU, CL_IMM, CL_LDI, CL_LD, CL_ST, CL_MULDIV,
        CL_UNARY, CL_BR, CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO
    } iclass_e;

    typedef struct packed {
        logic pc_out, zhi_out, zlow_out, mdr_out, hi_out, lo_out, inport_out, c_out, ba_out;
        logic pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, outport_in, con_in;
        logic gra, grb, grc, r_in, r_out, inc_pc, read, write;
        alu_op_e alu_op;
    } ctrl_t;

    // Final execute step of each class; the step after it is the fetch boundary.
    function automatic state_e last_step(iclass_e c);
        case (c)
            CL_UNARY:                    return S_T4;
            CL_ALU, CL_IMM, CL_LDI:      return S_T5;
            CL_MULDIV, CL_BR:            return S_T6;
            CL_LD, CL_ST:                return S_T7;
            default:                     return S_T3;
        endcase
    endfunction

endpackage

// File: rtl/control_decode.sv
// Opcode decoder: maps IR[31:27] to an instruction class and ALU select.
module control_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output iclass_e    iclass,
    output alu_op_e    alu_op
);

    always_comb begin
        iclass = CL_NOP;
        alu_op = ALU_NOP;
        case (opcode)
            OP_ADD:  begin iclass = CL_ALU;    alu_op = ALU_ADD;  end
            OP_SUB:  begin iclass = CL_ALU;    alu_op = ALU_SUB;  end
            OP_AND:  begin iclass = CL_ALU;    alu_op = ALU_AND;  end
            OP_OR:   begin iclass = CL_ALU;    alu_op = ALU_OR;   end
            OP_SHL:  begin iclass = CL_ALU;    alu_op = ALU_SHL;  end
            OP_SHR:  begin iclass = CL_ALU;    alu_op = ALU_SHR;  end
            OP_SHRA: begin iclass = CL_ALU;    alu_op = ALU_SHRA; end
            OP_ROR:  begin iclass = CL_ALU;    alu_op = ALU_ROR;  end
            OP_ROL:  begin iclass = CL_ALU;    alu_op = ALU_ROL;  end
            OP_ADDI: begin iclass = CL_IMM;    alu_op = ALU_ADD;  end
            OP_ANDI: begin iclass = CL_IMM;    alu_op = ALU_AND;  end
            OP_ORI:  begin iclass = CL_IMM;    alu_op = ALU_OR;   end
            // Address/branch-target arithmetic all goes through the adder.
            OP_LDI:  begin iclass = CL_LDI;    alu_op = ALU_ADD;  end
            OP_LD:   begin iclass = CL_LD;     alu_op = ALU_ADD;  end
            OP_ST:   begin iclass = CL_ST;     alu_op = ALU_ADD;  end
            OP_BR:   begin iclass = CL_BR;     alu_op = ALU_ADD;  end
            OP_MUL:  begin iclass = CL_MULDIV; alu_op = ALU_MUL;  end
            OP_DIV:  begin iclass = CL_MULDIV; alu_op = ALU_DIV;  end
            OP_NEG:  begin iclass = CL_UNARY;  alu_op = ALU_NEG;  end
            OP_NOT:  begin iclass = CL_UNARY;  alu_op = ALU_NOT;  end
            OP_JR:   iclass = CL_JR;
            OP_IN:   iclass = CL_IN;
            OP_OUT:  iclass = CL_OUT;
            OP_MFHI: iclass = CL_MFHI;
            OP_MFLO: iclass = CL_MFLO;
            OP_HALT: iclass = CL_HALT;
            default: iclass = CL_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control unit: fetch T0-T2, decode, execute T3-T7.
// Strobes are registered from the next state so each is valid for its own step.
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        Stop,
    output logic        PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout,
    output logic        PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, OutPortin, CONin,
    output logic        Gra, Grb, Grc, Rin, Rout,
    output logic        IncPC, Read, Write,
    output logic [3:0]  alu_op,
    output logic        Run
);

    state_e  state_q, state_d, end_state;
    ctrl_t   ctrl_q, ctrl_d;
    logic    run_q, run_d;
    iclass_e iclass;
    alu_op_e dec_alu;
    logic    ir_unused;

    assign ir_unused = ^IR[26:0];

    control_decode u_decode (
        .opcode (IR[31:27]),
        .iclass (iclass),
        .alu_op (dec_alu)
    );

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q <= S_T0;
            ctrl_q  <= '0;
            run_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        end_state = Stop ? S_HALT : S_T0;
        state_d   = state_q;
        case (state_q)
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2: begin
                if (iclass == CL_HALT)     state_d = S_HALT;
                else if (iclass == CL_NOP) state_d = end_state;
                else                       state_d = S_T3;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = (state_q == last_step(iclass)) ? end_state
                                                              : state_e'(state_q + 4'd1);
        endcase
    end

    always_comb begin
        ctrl_d = '0;
        run_d  = (state_d != S_HALT);
        case (state_d)
            S_T0: begin ctrl_d.pc_out = 1'b1; ctrl_d.mar_in = 1'b1; ctrl_d.inc_pc = 1'b1; ctrl_d.z_in = 1'b1; end
            S_T1: begin ctrl_d.zlow_out = 1'b1; ctrl_d.pc_in = 1'b1; ctrl_d.read = 1'b1; ctrl_d.mdr_in = 1'b1; end
            S_T2: begin ctrl_d.mdr_out = 1'b1; ctrl_d.ir_in = 1'b1; end
            S_HALT: ;
            default: begin
                case (iclass)
                    CL_ALU, CL_IMM: begin
                        case (state_d)
                            S_T3: begin ctrl_d.grb = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.y_in = 1'b1; end
                            S_T4: begin
                                if (iclass == CL_IMM) ctrl_d.c_out = 1'b1;
                                else begin ctrl_d.grc = 1'b1; ctrl_d.r_out = 1'b1; end
                                ctrl_d.z_in = 1'b1; ctrl_d.alu_op = dec_alu;
                            end
                            S_T5: begin ctrl_d.zlow_out = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    CL_LDI, CL_LD, CL_ST: begin
                        case (state_d)
                            S_T3: begin ctrl_d.grb = 1'b1; ctrl_d.ba_out = 1'b1; ctrl_d.y_in = 1'b1; end
                            S_T4: begin ctrl_d.c_out = 1'b1; ctrl_d.z_in = 1'b1; ctrl_d.alu_op = dec_alu; end
                            S_T5: begin
                                ctrl_d.zlow_out = 1'b1;
                                if (iclass == CL_LDI) begin ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
                                else ctrl_d.mar_in = 1'b1;
                            end
                            S_T6: begin
                                ctrl_d.mdr_in = 1'b1;
                                if (iclass == CL_LD) ctrl_d.read = 1'b1;
                                else begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; end
                            end
                            S_T7: begin
                                if (iclass == CL_LD) begin ctrl_d.mdr_out = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
                                else ctrl_d.write = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    CL_MULDIV: begin
                        case (state_d)
                            S_T3: begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.y_in = 1'b1; end
                            S_T4: begin ctrl_d.grb = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.z_in = 1'b1; ctrl_d.alu_op = dec_alu; end
                            S_T5: begin ctrl_d.zlow_out = 1'b1; ctrl_d.lo_in = 1'b1; end
                            S_T6: begin ctrl_d.zhi_out = 1'b1; ctrl_d.hi_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    CL_UNARY: begin
                        case (state_d)
                            S_T3: begin ctrl_d.grb = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.z_in = 1'b1; ctrl_d.alu_op = dec_alu; end
                            S_T4: begin ctrl_d.zlow_out = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    CL_BR: begin
                        case (state_d)
                            S_T3: begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.con_in = 1'b1; end
                            S_T4: begin ctrl_d.pc_out = 1'b1; ctrl_d.y_in = 1'b1; end
                            S_T5: begin ctrl_d.c_out = 1'b1; ctrl_d.z_in = 1'b1; ctrl_d.alu_op = dec_alu; end
                            // CON is looked at on the edge entering T6 only.
                            S_T6: if (CON) begin ctrl_d.zlow_out = 1'b1; ctrl_d.pc_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    CL_JR:   begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.pc_in = 1'b1; end
                    CL_IN:   begin ctrl_d.inport_out = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
                    CL_OUT:  begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.outport_in = 1'b1; end
                    CL_MFHI: begin ctrl_d.hi_out = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
                    CL_MFLO: begin ctrl_d.lo_out = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
                    default: ;
                endcase
            end
        endcase
    end

    assign PCout = ctrl_q.pc_out;     assign Zhiout = ctrl_q.zhi_out;   assign Zlowout = ctrl_q.zlow_out;
    assign MDRout = ctrl_q.mdr_out;   assign HIout = ctrl_q.hi_out;     assign LOout = ctrl_q.lo_out;
    assign InPortout = ctrl_q.inport_out; assign Cout = ctrl_q.c_out;   assign BAout = ctrl_q.ba_out;
    assign PCin = ctrl_q.pc_in;       assign MARin = ctrl_q.mar_in;     assign MDRin = ctrl_q.mdr_in;
    assign IRin = ctrl_q.ir_in;       assign Yin = ctrl_q.y_in;         assign Zin = ctrl_q.z_in;
    assign HIin = ctrl_q.hi_in;       assign LOin = ctrl_q.lo_in;       assign OutPortin = ctrl_q.outport_in;
    assign CONin = ctrl_q.con_in;     assign Gra = ctrl_q.gra;          assign Grb = ctrl_q.grb;
    assign Grc = ctrl_q.grc;          assign Rin = ctrl_q.r_in;         assign Rout = ctrl_q.r_out;
    assign IncPC = ctrl_q.inc_pc;     assign Read = ctrl_q.read;        assign Write = ctrl_q.write;
    assign alu_op = ctrl_q.alu_op;
    assign Run = run_q;

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control unit that drives the datapath's strobes and register-select lines. It replaces hand-sequenced testbench stimulus with a Moore FSM that fetches, decodes IR[31:27] and steps through T0..T7 per instruction. It sits beside the datapath: IR and CON come in, and every bus-out, register-in, memory and ALU-select control goes out.

## Interface
Parameters:
- none. Encodings come from `cpu_ctrl_pkg`.

Ports:
- `Clock`  in  1  Single clock. All state and outputs change on its rising edge.
- `Clear`  in  1  Synchronous, active-high reset.
- `IR`  in  32  Instruction register. Opcode is `IR[31:27]`.
- `CON`  in  1  Branch condition flip-flop output.
- `Stop`  in  1  Halt request. Taken at the next fetch boundary.
- `PCout`, `Zhiout`, `Zlowout`, `MDRout`, `HIout`, `LOout`, `InPortout`, `Cout`, `BAout`  out  1 each  Bus drivers.
- `PCin`, `MARin`, `MDRin`, `IRin`, `Yin`, `Zin`, `HIin`, `LOin`, `OutPortin`, `CONin`  out  1 each  Register loads.
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout`  out  1 each  Register-file select and enable.
- `IncPC`, `Read`, `Write`  out  1 each  PC increment and memory strobes.
- `alu_op`  out  4  ALU operation select. Encoding is in the package.
- `Run`  out  1  High while executing.

## Operation
- After `Clear`:
  - state is T0;
  - every control output is 0 and `alu_op` = `ALU_NOP`;
  - `Run` = 1.
- Outputs are registered and decoded from the next state, so each step's controls are valid for exactly the one cycle that step occupies.
- Fetch:
  - T0: `PCout` `MARin` `IncPC` `Zin`.
  - T1: `Zlowout` `PCin` `Read` `MDRin`.
  - T2: `MDRout` `IRin`.
- After T2, decode `IR[31:27]` and execute.
- Register ALU ops (add, sub, and, or, shl, shr, shra, ror, rol):
  - T3: `Grb` `Rout` `Yin`.
  - T4: `Grc` `Rout` `alu_op` `Zin`.
  - T5: `Zlowout` `Gra` `Rin`.
- Immediate ops (addi, andi, ori): same as register ALU ops, except T4 uses `Cout` in place of `Grc` `Rout`.
- ldi: T3 `Grb` `BAout` `Yin`; T4 `Cout` ADD `Zin`; T5 `Zlowout` `Gra` `Rin`.
- ld: same T3–T4 as ldi, then:
  - T5: `Zlowout` `MARin`.
  - T6: `Read` `MDRin`.
  - T7: `MDRout` `Gra` `Rin`.
- st: same T3–T5 as ld, then:
  - T6: `Gra` `Rout` `MDRin` (with `Read`=0).
  - T7: `Write`.
- mul, div:
  - T3: `Gra` `Rout` `Yin`.
  - T4: `Grb` `Rout` `alu_op` `Zin`.
  - T5: `Zlowout` `LOin`.
  - T6: `Zhiout` `HIin`.
- neg, not: T3 `Grb` `Rout` `alu_op` `Zin`; T4 `Zlowout` `Gra` `Rin`.
- br:
  - T3: `Gra` `Rout` `CONin`.
  - T4: `PCout` `Yin`.
  - T5: `Cout` ADD `Zin`.
  - T6: if `CON`=1, `Zlowout` `PCin`; otherwise no strobes. `CON` is sampled entering T6.
- Single-step ops (T3 only):
  - jr: `Gra` `Rout` `PCin`.
  - in: `InPortout` `Gra` `Rin`.
  - out: `Gra` `Rout` `OutPortin`.
  - mfhi: `HIout` `Gra` `Rin`.
  - mflo: `LOout` `Gra` `Rin`.
- nop and undefined opcodes: return to T0 after T2.
- halt: go to HALT, drop `Run`, all strobes 0. HALT is left only by `Clear`.
- After the final step of any instruction, go to T0. If `Stop`=1 at that edge, go to HALT instead.
- `Clear` mid-instruction: abandon the instruction immediately and return to the reset state. No partial `Write` or `Rin` is issued after that edge.

## Timing
- Total cycles including the 3-cycle fetch:
  - 4: jr, in, out, mfhi, mflo.
  - 5: neg, not.
  - 6: ALU, immediate and ldi ops.
  - 7: mul, div, br.
  - 8: ld, st.
- Never asserted in the same cycle:
  - `Read` and `Write`.
  - two bus drivers.
- `Clear` has priority over `Stop`, and `Stop` has priority over the next fetch.

## Structure
- `cpu_ctrl_pkg` contains:
  - opcode constants: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, addi 01011, andi 01100, ori 01101, mul 01110, div 01111, neg 10000, not 10001, br 10010, jr 10011, in 10100, out 10101, mflo 10110, mfhi 10111, nop 11000, halt 11001, shl 11010;
  - `alu_op` encoding;
  - state encoding: T0..T7 and HALT.
- One combinational sub-module, `control_decode`, maps the opcode to an instruction class and an `alu_op`. The FSM and output registers stay in `control_unit`.

## Test plan
- IR=0x590FFFFB (addi R2,R1,-5):
  - T3: `Grb` `Rout` `Yin`.
  - T4: `Cout`, `alu_op`=ADD, `Zin`.
  - T5: `Zlowout` `Gra` `Rin`.
  - Then T0 with `PCout` `MARin` `IncPC` `Zin`. Fetch to fetch is 6 cycles.
- ld (opcode 00000): `Read`+`MDRin` at T6, `MDRout`+`Gra`+`Rin` at T7. Next `PCout` exactly 8 cycles after the previous one.
- br, `CON`=0 then `CON`=1: T6 shows no strobes in the first case and `Zlowout`+`PCin` in the second. Both return to T0.
- halt (opcode 11001): `Run` falls one cycle after T2 and strobes stay 0 for 20 cycles. `Clear` restores `Run`=1 at T0.
- `Stop` raised during T4 of add: add completes its T5, then HALT with no T0.
- `Clear` asserted during T6 of st: no `Write` ever asserted. The next cycle is T0 with all outputs at their reset values.
